multicycle_sequencer: RTL and testbench

//   Multicycle control FSM that steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-ready timeout supervision.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic [1:0]       op,
  input  logic             reg_write_d,
  input  logic             mem_write_d,
  input  logic             mem_reg_d,
  input  logic             pc_src_d,
  input  logic             flag_write_d,
  input  logic             no_write_d,
  input  logic             cond_pass,
  output logic             imem_req,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             flag_we,
  output logic             retired,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc_s;
  logic [1:0]          op_q;
  logic                reg_write_q, mem_write_q, mem_reg_q, pc_src_q, flag_write_q, no_write_q;
  logic                timeout_s, retire_s;

  assign wait_inc_s = wait_q + WAIT_W'(1);
  // The wait that would bring the count up to the limit is the one that faults.
  assign timeout_s  = (MEM_TIMEOUT > 0) && (wait_inc_s == WAIT_LIM);

  // Next-state and strobe decode; ready/cond inputs act combinationally in their states.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    imem_req = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    reg_we   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    flag_we  = 1'b0;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!cond_pass) begin
          pc_en    = 1'b1;
          retire_s = 1'b1;
        end else begin
          case (op_q)
            2'b00: begin
              flag_we = flag_write_q;
              state_d = S_WB;
            end
            2'b01: begin
              state_d = S_MEM;
              wait_d  = '0;
            end
            2'b10: begin
              pc_en    = 1'b1;
              pc_sel   = 1'b1;
              retire_s = 1'b1;
            end
            default: state_d = S_FAULT;
          endcase
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write_q;
        if (dmem_ready) begin
          if (mem_reg_q) begin
            state_d = S_WB;
          end else begin
            pc_en    = 1'b1;
            retire_s = 1'b1;
          end
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_WB: begin
        reg_we   = reg_write_q & ~no_write_q;
        pc_en    = 1'b1;
        pc_sel   = pc_src_q;
        retire_s = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    if (retire_s) begin
      state_d = run ? S_FETCH : S_IDLE;
      wait_d  = '0;
    end else begin
      wait_d = wait_d;
    end
  end

  // State, wait counter and decode capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      op_q         <= 2'b00;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_reg_q    <= 1'b0;
      pc_src_q     <= 1'b0;
      flag_write_q <= 1'b0;
      no_write_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) begin
        op_q         <= op;
        reg_write_q  <= reg_write_d;
        mem_write_q  <= mem_write_d;
        mem_reg_q    <= mem_reg_d;
        pc_src_q     <= pc_src_d;
        flag_write_q <= flag_write_d;
        no_write_q   <= no_write_d;
      end
    end
  end

  assign retired = retire_s;
  assign state   = state_q;
  assign fault   = (state_q == S_FAULT);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire_s) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: each instruction is expanded into its expected per-cycle trace from the
// latency/strobe rules, then replayed against the sequencer with a per-cycle compare.
module tb_multicycle_sequencer;
  localparam int TO = 4;

  typedef struct packed {
    logic run, ir, dr;
    logic [1:0] op;
    logic rw, mw, mr, ps, fw, nw, cp;
  } stim_t;

  typedef struct packed {
    logic [2:0] st;
    logic flt, ireq, iren, pcen, pcsel, rwe, dreq, dwe, fwe, ret;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic run, imem_ready, dmem_ready, reg_write_d, mem_write_d, mem_reg_d;
  logic pc_src_d, flag_write_d, no_write_d, cond_pass;
  logic [1:0] op;
  logic imem_req, ir_en, pc_en, pc_sel, reg_we, dmem_req, dmem_we, flag_we, retired, fault;
  logic [2:0] state;
  logic [31:0] instr_count;

  int tests = 0, fails = 0;
  stim_t stim_q[$];
  exp_t  exp_q[$];
  logic [31:0] cnt_q[$];
  int model_cnt = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .op(op), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .mem_reg_d(mem_reg_d),
    .pc_src_d(pc_src_d), .flag_write_d(flag_write_d), .no_write_d(no_write_d),
    .cond_pass(cond_pass), .imem_req(imem_req), .ir_en(ir_en), .pc_en(pc_en),
    .pc_sel(pc_sel), .reg_we(reg_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .flag_we(flag_we), .retired(retired), .state(state), .fault(fault),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t actual();
    return {state, fault, imem_req, ir_en, pc_en, pc_sel, reg_we, dmem_req, dmem_we, flag_we, retired};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic add(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
`ifdef PERF_CNT_EN
    cnt_q.push_back(32'(model_cnt));
    if (e.ret) model_cnt++;
`else
    cnt_q.push_back(32'd0);
`endif
  endtask

  task automatic add_idle(input int n, input logic r);
    stim_t s;
    s = '0;
    s.run = r;
    for (int i = 0; i < n; i++) add(s, exp_t'(0));
  endtask

  task automatic add_fault(input int n);
    exp_t e;
    e = '0;
    e.st = 3'd7;
    e.flt = 1'b1;
    for (int i = 0; i < n; i++) add(stim_t'(0), e);
  endtask

  // Expected trace of one instruction from FETCH entry; other-cycle decode inputs are inverted.
  task automatic add_instr(input logic [1:0] iop, input logic rw, mw, mr, ps, fw, nw, cp,
                           input int iw, dw, input logic run_after);
    stim_t bg, s;
    exp_t e;
    bg = '{run: ~run_after, ir: 1'b0, dr: 1'b0, op: ~iop, rw: ~rw, mw: ~mw, mr: ~mr,
           ps: ~ps, fw: ~fw, nw: ~nw, cp: ~cp};
    for (int i = 0; ; i++) begin
      s = bg; e = '0; e.st = 3'd1; e.ireq = 1'b1;
      if (i == iw) begin
        s.ir = 1'b1; e.iren = 1'b1; add(s, e); break;
      end else if (i + 1 == TO) begin
        add(s, e); add_fault(3); return;
      end else add(s, e);
    end
    s = bg; s.op = iop; s.rw = rw; s.mw = mw; s.mr = mr; s.ps = ps; s.fw = fw; s.nw = nw;
    e = '0; e.st = 3'd2;
    add(s, e);
    s = bg; s.cp = cp; e = '0; e.st = 3'd3;
    if (!cp || iop == 2'b10) begin
      e.pcen = 1'b1; e.pcsel = cp; e.ret = 1'b1; s.run = run_after; add(s, e); return;
    end
    if (iop == 2'b11) begin
      add(s, e); add_fault(3); return;
    end
    if (iop == 2'b00) begin
      e.fwe = fw; add(s, e);
    end else begin
      add(s, e);
      for (int i = 0; ; i++) begin
        s = bg; e = '0; e.st = 3'd4; e.dreq = 1'b1; e.dwe = mw;
        if (i == dw) begin
          s.dr = 1'b1;
          if (mr) begin
            add(s, e); break;
          end
          e.pcen = 1'b1; e.ret = 1'b1; s.run = run_after; add(s, e); return;
        end else if (i + 1 == TO) begin
          add(s, e); add_fault(3); return;
        end else add(s, e);
      end
    end
    s = bg; s.run = run_after; e = '0; e.st = 3'd5;
    e.rwe = rw & ~nw; e.pcen = 1'b1; e.pcsel = ps; e.ret = 1'b1;
    add(s, e);
  endtask

  task automatic drive(input stim_t s);
    {run, imem_ready, dmem_ready, op, reg_write_d, mem_write_d, mem_reg_d, pc_src_d,
     flag_write_d, no_write_d, cond_pass} = s;
  endtask

  // Replay up to n queued cycles: drive after the rising edge, compare at the falling edge.
  task automatic run_q(input int n);
    stim_t s; exp_t e; logic [31:0] c;
    for (int k = 0; k < n && stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); c = cnt_q.pop_front();
      @(posedge clk); #1 drive(s);
      @(negedge clk);
      tests++;
      if (actual() !== e || instr_count !== c) begin
        fails++;
        $display("FAIL cycle t=%0t got={st,flt,ireq,iren,pcen,pcsel,rwe,dreq,dwe,fwe,ret}=%b cnt=%0d want=%b cnt=%0d",
                 $time, actual(), instr_count, e, c);
      end
    end
  endtask

  task automatic do_reset();
    drive(stim_t'(0));
    rst_n = 1'b0;
    stim_q.delete(); exp_q.delete(); cnt_q.delete();
    model_cnt = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {actual(), instr_count}, 45'd0);
    rst_n = 1'b1;
  endtask

  int b, nmem;

  initial begin
    do_reset();
    add_idle(2, 1'b0);
    add_idle(1, 1'b1);
    // ADD r1: pin model trace F,D,E,WB with retire and reg write only in WB.
    b = exp_q.size();
    add_instr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    chk("model_add_len", exp_q.size() - b, 4);
    chk("model_add_states", {exp_q[b].st, exp_q[b+1].st, exp_q[b+2].st, exp_q[b+3].st}, 12'o1235);
    chk("model_add_wb", {exp_q[b+3].ret, exp_q[b+3].rwe, exp_q[b+2].rwe, exp_q[b+2].ret}, 4'b1100);
    // CMP: flag write in EXEC, no register write in WB.
    b = exp_q.size();
    add_instr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1'b1);
    chk("model_cmp", {exp_q[b+3].fwe, exp_q[b+4].rwe}, 2'b10);
    // LDR, 3 data waits: 8 cycles with 4 of dmem_req.
    b = exp_q.size();
    add_instr(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1'b1);
    nmem = 0;
    for (int i = b; i < exp_q.size(); i++) if (exp_q[i].dreq) nmem++;
    chk("model_ldr_len", exp_q.size() - b, 8);
    chk("model_ldr_dreq", nmem, 4);
    add_instr(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);  // STR
    add_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);  // branch, cond fail
    add_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);  // branch taken
    add_instr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);  // data, cond fail
    add_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 1'b0);  // ready at fetch limit
    add_idle(2, 1'b0);
    add_idle(1, 1'b1);
    add_instr(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);  // data to pc
    add_instr(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 1'b0);  // STR with waits
    add_idle(3, 1'b0);
    run_q(1000);
`ifdef PERF_CNT_EN
    chk("instr_count_10", instr_count, 32'd10);
`else
    chk("instr_count_tied", instr_count, 32'd0);
`endif
    // Data timeout: 4 MEM cycles then sticky FAULT.
    add_idle(1, 1'b1);
    b = exp_q.size();
    add_instr(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 100, 1'b1);
    nmem = 0;
    for (int i = b; i < exp_q.size(); i++) if (exp_q[i].st == 3'd4) nmem++;
    chk("model_timeout_mem", nmem, 4);
    run_q(1000);
    chk("fault_sticky", {fault, state}, {1'b1, 3'd7});
    // Async reset in the middle of a pending store.
    do_reset();
    add_idle(1, 1'b1);
    add_instr(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 100, 1'b1);
    run_q(5);
    chk("mid_mem_before_reset", {state, dmem_req, dmem_we}, {3'd4, 2'b11});
    #2 rst_n = 1'b0;
    #1 chk("mid_mem_reset_async", {actual(), instr_count}, 45'd0);
    do_reset();
    // Illegal opcode faults without retiring.
    add_idle(1, 1'b1);
    add_instr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    run_q(1000);
    chk("illegal_fault", {fault, state}, {1'b1, 3'd7});
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
